cache_fill_arbiter: RTL and testbench

Shares the single main-memory port between the instruction-cache miss path and the data-cache miss/write-through path of the pipelined CPU. It arbitrates requests, then sequences 8-word block fills against a pipelined fixed-latency memory. It also issues single-word store writes and returns fill data with per-word write enables to the requesting cache. It sits between the two cache controllers and the unified memory model. Pipeline stalls are derived by the caches from their pending request and the done pulses.

---
 rtl/cache_fill_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter
//   Shares the single main-memory port between the I-cache miss path and the
//   D-cache miss / store write-through path. Store writes beat fills; the two
//   fill requesters alternate on ties. A fill issues BLOCK_WORDS back-to-back
//   reads and streams the returning words to the granted cache with a
//   per-word write enable and a done pulse on the final word.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   icache_miss / icache_miss_addr     I-fill request (level) and byte address
//   dcache_miss / dcache_miss_addr     D-fill request (level) and byte address
//   dcache_wr / _addr / _data          store write-through request
//   mem_en, mem_wr, mem_addr, mem_wdata    memory command
//   mem_data_out, mem_data_valid       memory read return
//   fill_data, fill_word               returned word and its block offset
//   ifill_we, dfill_we                 per-word write enable to each cache
//   ifill_done, dfill_done             block-complete pulse
//   wr_ack                             store issued pulse
module cache_fill_arbiter #(
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           icache_miss,
    input  logic [15:0]                    icache_miss_addr,
    input  logic                           dcache_miss,
    input  logic [15:0]                    dcache_miss_addr,
    input  logic                           dcache_wr,
    input  logic [15:0]                    dcache_wr_addr,
    input  logic [15:0]                    dcache_wr_data,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [15:0]                    mem_addr,
    output logic [15:0]                    mem_wdata,
    input  logic [15:0]                    mem_data_out,
    input  logic                           mem_data_valid,
    output logic [15:0]                    fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           ifill_we,
    output logic                           dfill_we,
    output logic                           ifill_done,
    output logic                           dfill_done,
    output logic                           wr_ack
);

    localparam int          WW       = $clog2(BLOCK_WORDS);
    localparam int          CW       = WW + 1;
    localparam logic [15:0] BLK_MASK = ~16'(2 * BLOCK_WORDS - 1);
    localparam logic [CW-1:0] LAST   = CW'(BLOCK_WORDS - 1);

    // Returns are counted off mem_data_valid, so the exact latency only has
    // to be legal; it never sizes any logic here.
    if (MEM_LATENCY < 1 || BLOCK_WORDS < 2 ||
        (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_bad_params
        $error("cache_fill_arbiter: unsupported BLOCK_WORDS/MEM_LATENCY");
    end

    typedef enum logic [1:0] {IDLE, WRITE, FILL, DRAIN} state_t;

    state_t        state, state_n;
    logic          gnt_i;          // 1 = current fill belongs to the I-cache
    logic          last_fill;      // 1 = I-cache was the last fill served
    logic [15:0]   base_addr;
    logic [15:0]   st_addr;
    logic [15:0]   st_data;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] ret_cnt;

    logic in_fill, fill_last, arb_en;
    logic mask_wr, mask_d, mask_i;
    logic wr_req, d_req, i_req;
    logic pick_wr, pick_d, pick_i;

    // Arbitration also runs in the completing cycle of a store or fill so the
    // next grant follows with no idle gap. The requester being completed still
    // holds its request that cycle, so it is masked out of that decision.
    always_comb begin
        in_fill   = (state == FILL) || (state == DRAIN);
        fill_last = in_fill && mem_data_valid && (ret_cnt == LAST);
        arb_en    = 1'b0;
        mask_wr   = 1'b0;
        mask_d    = 1'b0;
        mask_i    = 1'b0;
        case (state)
            IDLE:    arb_en = 1'b1;
            WRITE: begin
                arb_en  = 1'b1;
                mask_wr = 1'b1;
            end
            default: if (fill_last) begin
                arb_en = 1'b1;
                mask_d = ~gnt_i;
                mask_i = gnt_i;
            end
        endcase
        wr_req  = dcache_wr & ~mask_wr;
        d_req   = dcache_miss & ~mask_d;
        i_req   = icache_miss & ~mask_i;
        pick_wr = arb_en & wr_req;
        pick_d  = arb_en & ~wr_req & d_req & (~i_req | last_fill);
        pick_i  = arb_en & ~wr_req & i_req & ~pick_d;

        state_n = state;
        if (arb_en)
            state_n = pick_wr ? WRITE : ((pick_d | pick_i) ? FILL : IDLE);
        else if (state == FILL && issue_cnt == LAST)
            state_n = DRAIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_i     <= 1'b0;
            last_fill <= 1'b1;
            base_addr <= '0;
            st_addr   <= '0;
            st_data   <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            state <= state_n;
            if (pick_wr) begin
                st_addr <= dcache_wr_addr;
                st_data <= dcache_wr_data;
            end
            if (pick_d | pick_i) begin
                gnt_i     <= pick_i;
                base_addr <= (pick_i ? icache_miss_addr : dcache_miss_addr) & BLK_MASK;
                issue_cnt <= '0;
            end else if (state == FILL) begin
                issue_cnt <= issue_cnt + CW'(1);
            end
            if (fill_last) begin
                ret_cnt   <= '0;
                last_fill <= gnt_i;
            end else if (in_fill && mem_data_valid) begin
                ret_cnt <= ret_cnt + CW'(1);
            end
        end
    end

    // Memory-side outputs come from registered state only.
    always_comb begin
        mem_en    = (state == WRITE) || (state == FILL);
        mem_wr    = (state == WRITE);
        wr_ack    = (state == WRITE);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == WRITE) begin
            mem_addr  = st_addr;
            mem_wdata = st_data;
        end else if (state == FILL) begin
            mem_addr = base_addr + (16'(issue_cnt) << 1);
        end
    end

    assign fill_data  = mem_data_out;
    assign fill_word  = ret_cnt[WW-1:0];
    assign ifill_we   = in_fill & mem_data_valid & gnt_i;
    assign dfill_we   = in_fill & mem_data_valid & ~gnt_i;
    assign ifill_done = fill_last & gnt_i;
    assign dfill_done = fill_last & ~gnt_i;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: random requesters plus a transaction-level
// schedule model. Each grant is turned into the list of cycles at which every
// output must show activity; all other cycles expect idle outputs.
module tb_cache_fill_arbiter;
    localparam int BW = 8;
    localparam int L  = 4;
    localparam int NC = 4096;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        icache_miss, dcache_miss, dcache_wr;
    logic [15:0] icache_miss_addr, dcache_miss_addr, dcache_wr_addr, dcache_wr_data;
    logic        mem_en, mem_wr, mem_data_valid;
    logic [15:0] mem_addr, mem_wdata, mem_data_out, fill_data;
    logic [2:0]  fill_word;
    logic        ifill_we, dfill_we, ifill_done, dfill_done, wr_ack;

    cache_fill_arbiter #(.BLOCK_WORDS(BW), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
        .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
        .dcache_wr(dcache_wr), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .ifill_we(ifill_we), .dfill_we(dfill_we),
        .ifill_done(ifill_done), .dfill_done(dfill_done), .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] hash(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Fixed-latency pipelined memory sharing the reset.
    logic [L-1:0] mv;
    logic [15:0]  ma [L];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv <= '0;
            for (int i = 0; i < L; i++) ma[i] <= '0;
        end else begin
            mv    <= {mv[L-2:0], mem_en & ~mem_wr};
            ma[0] <= mem_addr;
            for (int i = 1; i < L; i++) ma[i] <= ma[i-1];
        end
    end
    assign mem_data_valid = mv[L-1];
    assign mem_data_out   = mv[L-1] ? hash(ma[L-1]) : 16'h0;

    typedef struct packed {
        logic en, wr;
        logic [15:0] addr, wdata;
        logic iwe, dwe;
        logic [2:0] word;
        logic [15:0] fdata;
        logic idone, ddone, ack;
    } exp_t;
    exp_t ex [NC];

    int checks = 0, errors = 0, cyc = 0;
    int pw, pm;
    bit w_pend, d_pend, i_pend, busy, last_i;
    logic [15:0] w_addr, w_data, d_addr, i_addr;
    int who, end_cyc;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, want);
        end
    endtask

    task automatic compare();
        exp_t e;
        e = ex[cyc];
        chk("mem_en",     16'(mem_en),     16'(e.en));
        chk("mem_wr",     16'(mem_wr),     16'(e.wr));
        chk("mem_addr",   mem_addr,        e.addr);
        chk("mem_wdata",  mem_wdata,       e.wdata);
        chk("ifill_we",   16'(ifill_we),   16'(e.iwe));
        chk("dfill_we",   16'(dfill_we),   16'(e.dwe));
        chk("fill_word",  16'(fill_word),  16'(e.word));
        chk("fill_data",  fill_data,       e.fdata);
        chk("ifill_done", 16'(ifill_done), 16'(e.idone));
        chk("dfill_done", 16'(dfill_done), 16'(e.ddone));
        chk("wr_ack",     16'(wr_ack),     16'(e.ack));
    endtask

    task automatic sched_fill(input int w, input logic [15:0] a);
        logic [15:0] b;
        b = a & ~16'(2 * BW - 1);
        who = w; busy = 1; end_cyc = cyc + BW + L;
        for (int k = 0; k < BW; k++) begin
            ex[cyc+1+k].en     = 1'b1;
            ex[cyc+1+k].addr   = b + 16'(2 * k);
            ex[cyc+1+k+L].iwe  = (w == 2);
            ex[cyc+1+k+L].dwe  = (w == 1);
            ex[cyc+1+k+L].word = 3'(k);
            ex[cyc+1+k+L].fdata = hash(b + 16'(2 * k));
        end
        ex[end_cyc].idone = (w == 2);
        ex[end_cyc].ddone = (w == 1);
    endtask

    // Store first; among fills the one not served last wins a tie. A finishing
    // transaction frees the port in its completion cycle.
    task automatic model();
        if (busy && cyc == end_cyc) begin
            busy = 0;
            if (who == 0) w_pend = 0;
            else if (who == 1) begin d_pend = 0; last_i = 0; end
            else begin i_pend = 0; last_i = 1; end
        end
        if (!busy) begin
            if (w_pend) begin
                who = 0; busy = 1; end_cyc = cyc + 1;
                ex[cyc+1].en = 1'b1; ex[cyc+1].wr = 1'b1; ex[cyc+1].ack = 1'b1;
                ex[cyc+1].addr = w_addr; ex[cyc+1].wdata = w_data;
            end else if (d_pend && (!i_pend || last_i)) sched_fill(1, d_addr);
            else if (i_pend) sched_fill(2, i_addr);
        end
    endtask

    task automatic drive();
        dcache_wr = w_pend; dcache_wr_addr = w_addr; dcache_wr_data = w_data;
        dcache_miss = d_pend; dcache_miss_addr = d_addr;
        icache_miss = i_pend; icache_miss_addr = i_addr;
    endtask

    task automatic step();
        @(posedge clk); #1; cyc++;
        if (!w_pend && $urandom_range(99) < pw) begin
            w_pend = 1; w_addr = 16'($urandom); w_data = 16'($urandom);
        end
        if (!d_pend && $urandom_range(99) < pm) begin d_pend = 1; d_addr = 16'($urandom); end
        if (!i_pend && $urandom_range(99) < pm) begin i_pend = 1; i_addr = 16'($urandom); end
        drive();
        model();
        @(negedge clk); compare();
    endtask

    task automatic drain();
        pw = 0; pm = 0;
        for (int k = 0; k < 300 && (busy || w_pend || d_pend || i_pend); k++) step();
        chk("drain_timeout", 16'(busy), 16'd0);
    endtask

    initial begin
        int g;
        for (int k = 0; k < NC; k++) ex[k] = '0;
        w_pend = 0; d_pend = 0; i_pend = 0; busy = 0; last_i = 1;
        w_addr = '0; w_data = '0; d_addr = '0; i_addr = '0;
        pw = 0; pm = 0;
        drive();
        #3 compare();              // reset state
        #9 rst_n = 1'b1;

        // All three requesters at once: store, then D-fill, then I-fill.
        w_pend = 1; w_addr = 16'h00A4; w_data = 16'hBEEF;
        d_pend = 1; d_addr = 16'h3456;
        i_pend = 1; i_addr = 16'h789A;
        repeat (40) step();

        pw = 10; pm = 15; repeat (600) step();
        pw = 0;  pm = 100; repeat (300) step();   // misses held: strict alternation
        pw = 30; pm = 60; repeat (500) step();
        drain();

        // Reset while the I-fill of 0x1236 returns word 3.
        i_pend = 1; i_addr = 16'h1236;
        step(); g = cyc;
        while (cyc < g + 3 + L) step();
        @(posedge clk); #1; cyc++;
        chk("pre_rst_we",   16'(ifill_we),  16'd1);
        chk("pre_rst_word", 16'(fill_word), 16'd3);
        rst_n = 1'b0; #1;
        busy = 0; w_pend = 0; d_pend = 0; i_pend = 0; last_i = 1;
        drive();
        for (int k = cyc; k < NC; k++) ex[k] = '0;
        compare();
        @(negedge clk); compare();
        step(); step();
        #1 rst_n = 1'b1;

        i_pend = 1; i_addr = 16'h0F0E;
        pw = 15; pm = 30; repeat (300) step();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
